// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and byte-lane constants for the instruction fetch sequencer
package fetch_pkg;

    // One state per step of the two-byte fetch sequence.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        WR_LO  = 3'd2,
        REQ_HI = 3'd3,
        WR_HI  = 3'd4,
        DONE   = 3'd5
    } fetch_state_t;

    // Instruction register byte-lane select values.
    localparam logic LH_LOW  = 1'b0;
    localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with async reset, parallel load and modulo increment
module fetch_pc_reg #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    // Load wins over increment; the increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// rtl/instruction_fetch_sequencer.sv - fetches a 16-bit instruction as two byte writes to the instruction register
module instruction_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              MemReady,
    input  logic [7:0]        MemData,
    output logic [7:0]        IRData,
    output logic              IRWrite,
    output logic              IRLH,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Done
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic         capture;
    logic         pc_load;
    logic         pc_incr;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (pc_load),
        .load_value (PCIn),
        .incr       (pc_incr),
        .pc         (PC)
    );

    // Memory is always addressed by the PC; it only moves in WR_* or IDLE, so it is stable during waits.
    assign MemAddr = PC;
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);

    // State register; reset abandons any fetch in progress.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; MemRead is additionally gated by Stall.
    always_comb begin
        next_state = state;
        MemRead    = 1'b0;
        IRWrite    = 1'b0;
        IRLH       = LH_LOW;
        capture    = 1'b0;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;
        case (state)
            IDLE: begin
                // A PC load consumes the cycle, so a simultaneous Start is dropped.
                if (PCLoad) begin
                    pc_load = 1'b1;
                end else if (Start && !Stall) begin
                    next_state = REQ_LO;
                end
            end
            REQ_LO: begin
                MemRead = ~Stall;
                capture = MemRead & MemReady;
                if (capture) begin
                    next_state = WR_LO;
                end
            end
            WR_LO: begin
                IRWrite    = 1'b1;
                IRLH       = LH_LOW;
                pc_incr    = 1'b1;
                next_state = REQ_HI;
            end
            REQ_HI: begin
                MemRead = ~Stall;
                capture = MemRead & MemReady;
                if (capture) begin
                    next_state = WR_HI;
                end
            end
            WR_HI: begin
                IRWrite    = 1'b1;
                IRLH       = LH_HIGH;
                pc_incr    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte holding register feeding the instruction register; keeps its value between captures.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            IRData <= 8'h00;
        end else if (capture) begin
            IRData <= MemData;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb/tb_instruction_fetch_sequencer.sv - randomized self-checking bench for instruction_fetch_sequencer
module tb_instruction_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Stall = 1'b0;
    logic        PCLoad = 1'b0;
    logic [15:0] PCIn = 16'h0000;
    logic        MemReady = 1'b0;
    logic [7:0]  MemData;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic [7:0]  IRData;
    logic        IRWrite;
    logic        IRLH;
    logic [15:0] PC;
    logic        Busy;
    logic        Done;

    logic [7:0]  mem [0:65535];
    logic [15:0] model_pc;
    logic [15:0] ir_model;
    int          vectors = 0;
    int          miscompares = 0;

    instruction_fetch_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Stall    (Stall),
        .PCLoad   (PCLoad),
        .PCIn     (PCIn),
        .MemAddr  (MemAddr),
        .MemRead  (MemRead),
        .MemReady (MemReady),
        .MemData  (MemData),
        .IRData   (IRData),
        .IRWrite  (IRWrite),
        .IRLH     (IRLH),
        .PC       (PC),
        .Busy     (Busy),
        .Done     (Done)
    );

    assign MemData = mem[MemAddr];

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_pc(input logic [15:0] v);
        @(negedge Clock);
        PCLoad = 1'b1;
        PCIn   = v;
        @(negedge Clock);
        PCLoad = 1'b0;
        #1;
        check("load_pc", PC, v);
        model_pc = v;
    endtask

    // One instruction fetch: wl/wh wait cycles per byte, st stall cycles at the start of REQ_LO,
    // noise toggles Start/PCLoad while the fetch is in flight.
    task automatic fetch(input int wl, input int wh, input int st, input bit noise);
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] prev_addr;
        int          byte_i;
        int          cnt;
        int          writes;
        bit          done_seen;
        bit          waiting;
        a0        = model_pc;
        a1        = model_pc + 16'd1;
        byte_i    = 0;
        cnt       = 0;
        writes    = 0;
        done_seen = 1'b0;
        waiting   = 1'b0;
        prev_addr = a0;
        @(negedge Clock);
        Start    = 1'b1;
        PCLoad   = 1'b0;
        Stall    = 1'b0;
        MemReady = 1'b0;
        #1;
        check("idle_busy", Busy, 1'b0);
        for (int k = 1; k <= 60 && !done_seen; k++) begin
            @(negedge Clock);
            Start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            PCLoad = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            PCIn   = 16'($urandom);
            Stall  = (k <= st);
            #1;
            check("memaddr_pc", MemAddr, PC);
            if (waiting) check("addr_stable", MemAddr, prev_addr);
            if (k <= st) check("stall_memread", MemRead, 1'b0);
            if (IRWrite) begin
                writes++;
                if (writes == 1) begin
                    check("lh_lo", IRLH, 1'b0);
                    check("data_lo", IRData, mem[a0]);
                    ir_model[7:0] = IRData;
                end else begin
                    check("lh_hi", IRLH, 1'b1);
                    check("data_hi", IRData, mem[a1]);
                    ir_model[15:8] = IRData;
                end
            end
            if (Done) begin
                done_seen = 1'b1;
                check("done_cycle", k, 5 + wl + wh + st);
            end
            if (MemRead) begin
                MemReady = (cnt >= ((byte_i == 0) ? wl : wh));
                if (MemReady) begin
                    check("rd_addr", MemAddr, (byte_i == 0) ? a0 : a1);
                    byte_i++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                MemReady = 1'($urandom_range(0, 1));
            end
            waiting   = MemRead && !MemReady;
            prev_addr = MemAddr;
        end
        Start  = 1'b0;
        PCLoad = 1'b0;
        Stall  = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
        check("write_count", writes, 2);
        check("ir_word", ir_model, {mem[a1], mem[a0]});
        model_pc = a0 + 16'd2;
        @(negedge Clock);
        MemReady = 1'b0;
        #1;
        check("pc_after", PC, model_pc);
        check("busy_after", Busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        #3 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        check("rst_pc", PC, 16'h0000);
        check("rst_busy", Busy, 1'b0);
        check("rst_memread", MemRead, 1'b0);
        check("rst_irwrite", IRWrite, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_irdata", IRData, 8'h00);
        @(negedge Clock);
        Reset    = 1'b1;
        model_pc = 16'h0000;

        // Basic zero-wait fetch from address 0
        mem[0] = 8'h34;
        mem[1] = 8'h12;
        fetch(0, 0, 0, 1'b0);
        check("basic_ir", ir_model, 16'h1234);

        // Three wait cycles on each byte
        load_pc(16'h0000);
        fetch(3, 3, 0, 1'b0);
        check("wait_ir", ir_model, 16'h1234);

        // PC wrap across FFFF
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        load_pc(16'hFFFF);
        fetch(0, 0, 0, 1'b0);
        check("wrap_ir", ir_model, 16'hABCD);
        check("wrap_pc", PC, 16'h0001);

        // Two stall cycles in REQ_LO
        fetch(0, 0, 2, 1'b0);

        // Start/PCLoad noise while busy
        fetch(1, 0, 0, 1'b1);

        // PCLoad and Start together in IDLE
        @(negedge Clock);
        PCLoad = 1'b1;
        Start  = 1'b1;
        PCIn   = 16'h4321;
        @(negedge Clock);
        PCLoad = 1'b0;
        Start  = 1'b0;
        #1;
        check("ld_start_pc", PC, 16'h4321);
        check("ld_start_busy", Busy, 1'b0);
        @(negedge Clock);
        #1;
        check("ld_start_busy2", Busy, 1'b0);
        model_pc = 16'h4321;

        // Reset asserted while waiting in REQ_HI
        mem[16'h4321] = 8'h5A;
        mem[16'h4322] = 8'hA5;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        #1;
        MemReady = 1'b1;
        @(negedge Clock);
        #1;
        MemReady = 1'b0;
        @(negedge Clock);
        #1;
        check("mid_memread", MemRead, 1'b1);
        check("mid_addr", MemAddr, 16'h4322);
        Reset = 1'b0;
        #1;
        check("amid_memread", MemRead, 1'b0);
        check("amid_irwrite", IRWrite, 1'b0);
        check("amid_irlh", IRLH, 1'b0);
        check("amid_busy", Busy, 1'b0);
        check("amid_done", Done, 1'b0);
        check("amid_irdata", IRData, 8'h00);
        check("amid_pc", PC, 16'h0000);
        @(negedge Clock);
        Reset    = 1'b1;
        MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            #1;
            check("post_rst_irwrite", IRWrite, 1'b0);
            check("post_rst_busy", Busy, 1'b0);
        end
        MemReady = 1'b0;
        model_pc = 16'h0000;

        // Randomized fetches
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load_pc(16'($urandom));
            mem[model_pc]         = 8'($urandom);
            mem[model_pc + 16'd1] = 8'($urandom);
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
